// File: rtl/sram_resp_tracker_pkg.sv
// Shared constants for the sram-like response trackers: issuer tag encodings and
// the width helper used for the outstanding-count port.
package sram_resp_tracker_pkg;

   // Inst port issuers (TAG_W=1)
   localparam int SRT_TAG_PFS = 0;
   localparam int SRT_TAG_FS  = 1;
   // Data port issuers (TAG_W=1)
   localparam int SRT_TAG_ES  = 0;
   localparam int SRT_TAG_MS  = 1;

   function automatic int srt_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sram_resp_tracker.sv
// In-flight request tracker for one sram-like port: a circular FIFO of {disc, tag}
// entries that routes in-order responses back to their issuer and swallows flushed ones.
module sram_resp_tracker
   import sram_resp_tracker_pkg::*;
#(
   parameter  int DEPTH  = 2,
   parameter  int TAG_W  = 1,
   parameter  int DATA_W = 32,
   localparam int CW     = srt_cw(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              up_req,
   input  logic [TAG_W-1:0]  up_tag,
   output logic              sram_req,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              flush,
   output logic              up_accept,
   output logic              resp_valid,
   output logic [TAG_W-1:0]  resp_tag,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [CW-1:0]     outstanding,
   output logic              full,
   output logic              proto_err
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [CW-1:0]    r_count;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [DEPTH-1:0] r_disc;
   logic [TAG_W-1:0] r_tag [DEPTH];
   logic             r_proto_err;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic [PW-1:0]    w_wr_nxt;
   logic [PW-1:0]    w_rd_nxt;

   // Full is taken from the registered count, so a pop never opens a slot for a same-cycle push.
   assign w_full   = (r_count == CNT_MAX);
   assign w_empty  = (r_count == '0);
   assign w_pop    = sram_data_ok & ~w_empty;
   assign w_wr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);

   assign sram_req    = up_req & ~w_full;
   assign up_accept   = sram_req & sram_addr_ok;
   assign resp_valid  = w_pop & ~r_disc[r_rd_ptr] & ~flush;
   assign resp_tag    = r_tag[r_rd_ptr];
   assign resp_rdata  = sram_rdata;
   assign outstanding = r_count;
   assign full        = w_full;
   assign proto_err   = r_proto_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_disc      <= '0;
         r_proto_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
      end else begin
         // Marking free slots too is harmless: a push always rewrites its disc bit.
         if (flush) r_disc <= '1;
         if (up_accept) begin
            r_disc[r_wr_ptr] <= flush;
            r_tag[r_wr_ptr]  <= up_tag;
            r_wr_ptr         <= w_wr_nxt;
         end
         if (w_pop) r_rd_ptr <= w_rd_nxt;
         if (up_accept && !w_pop)      r_count <= r_count + CW'(1);
         else if (!up_accept && w_pop) r_count <= r_count - CW'(1);
         if (sram_data_ok && w_empty) r_proto_err <= 1'b1;
      end
   end

endmodule
